// File: rtl/tqvp_bus_initiator.sv
// Host-side initiator for the TinyQV peripheral bus.
// Issues one read or write per request and returns data, timeout or error status.
module tqvp_bus_initiator #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [5:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_timeout,
  output logic        rsp_err,
  output logic [5:0]  per_address,
  output logic [31:0] per_data_in,
  output logic [1:0]  per_data_write_n,
  output logic [1:0]  per_data_read_n,
  input  logic [31:0] per_data_out,
  input  logic        per_data_ready,
  input  logic        per_user_interrupt,
  output logic        irq_rise
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;
  localparam logic [1:0] S_RSP  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state;
  logic [1:0]       size_q;
  logic [CNT_W-1:0] cnt;
  logic             irq_prev;
  logic [31:0]      rd_masked;

  always_comb begin
    rd_masked = per_data_out;
    unique case (1'b1)
      size_q == 2'b00: rd_masked = {24'b0, per_data_out[7:0]};
      size_q == 2'b01: rd_masked = {16'b0, per_data_out[15:0]};
      default:         rd_masked = per_data_out;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      size_q           <= 2'b00;
      cnt              <= '0;
      req_ready        <= 1'b0;
      rsp_valid        <= 1'b0;
      rsp_rdata        <= '0;
      rsp_timeout      <= 1'b0;
      rsp_err          <= 1'b0;
      per_address      <= '0;
      per_data_in      <= '0;
      per_data_write_n <= 2'b11;
      per_data_read_n  <= 2'b11;
      irq_prev         <= 1'b0;
      irq_rise         <= 1'b0;
    end else begin
      irq_prev <= per_user_interrupt;
      irq_rise <= per_user_interrupt & ~irq_prev;
      unique case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            size_q    <= req_size;
            cnt       <= '0;
            if (req_size == 2'b11) begin
              state     <= S_RSP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              per_address <= req_addr;
              per_data_in <= req_wdata;
              if (req_write) begin
                state            <= S_WR;
                per_data_write_n <= req_size;
              end else begin
                state           <= S_RD;
                per_data_read_n <= req_size;
              end
            end
          end
        end
        S_WR: begin
          per_data_write_n <= 2'b11;
          state            <= S_RSP;
          rsp_valid        <= 1'b1;
          rsp_rdata        <= '0;
        end
        S_RD: begin
          cnt <= cnt + 1'b1;
          // data_ready on the final cycle takes priority over the timeout
          if (per_data_ready) begin
            per_data_read_n <= 2'b11;
            state           <= S_RSP;
            rsp_valid       <= 1'b1;
            rsp_rdata       <= rd_masked;
          end else if (cnt == CNT_LAST) begin
            per_data_read_n <= 2'b11;
            state           <= S_RSP;
            rsp_valid       <= 1'b1;
            rsp_timeout     <= 1'b1;
            rsp_rdata       <= '0;
          end
        end
        default: begin
          if (rsp_ready) begin
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            state       <= S_IDLE;
            req_ready   <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tqvp_bus_initiator.sv
// Directed bench for tqvp_bus_initiator.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_tqvp_bus_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_timeout;
  logic        rsp_err;
  logic [5:0]  per_address;
  logic [31:0] per_data_in;
  logic [1:0]  per_data_write_n;
  logic [1:0]  per_data_read_n;
  logic [31:0] per_data_out;
  logic        per_data_ready;
  logic        per_user_interrupt;
  logic        irq_rise;

  int vec = 0;
  int errs = 0;
  int pulses = 0;

  tqvp_bus_initiator #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_size(req_size),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_timeout(rsp_timeout),
    .rsp_err(rsp_err),
    .per_address(per_address),
    .per_data_in(per_data_in),
    .per_data_write_n(per_data_write_n),
    .per_data_read_n(per_data_read_n),
    .per_data_out(per_data_out),
    .per_data_ready(per_data_ready),
    .per_user_interrupt(per_user_interrupt),
    .irq_rise(irq_rise)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic w, input logic [1:0] sz,
                     input logic [5:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_size  = sz;
    req_addr  = a;
    req_wdata = d;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_clr", {31'b0, rsp_valid}, 32'd0);
    chk("rdy_back", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size = 2'b00;
    req_addr = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    per_data_out = '0;
    per_data_ready = 1'b0;
    per_user_interrupt = 1'b0;
    tick();
    tick();
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_wr_n", {30'b0, per_data_write_n}, 32'd3);
    chk("rst_rd_n", {30'b0, per_data_read_n}, 32'd3);
    chk("rst_addr", {26'b0, per_address}, 32'd0);
    chk("rst_irq", {31'b0, irq_rise}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rdy_after_rst", {31'b0, req_ready}, 32'd1);

    // 32-bit write
    req(1'b1, 2'b10, 6'h00, 32'hDEADBEEF);
    chk("wr_strobe", {30'b0, per_data_write_n}, 32'd2);
    chk("wr_addr", {26'b0, per_address}, 32'd0);
    chk("wr_data", per_data_in, 32'hDEADBEEF);
    chk("wr_busy", {31'b0, req_ready}, 32'd0);
    chk("wr_no_rsp", {31'b0, rsp_valid}, 32'd0);
    tick();
    chk("wr_release", {30'b0, per_data_write_n}, 32'd3);
    chk("wr_rsp", {31'b0, rsp_valid}, 32'd1);
    chk("wr_rdata", rsp_rdata, 32'd0);
    chk("wr_flags", {30'b0, rsp_err, rsp_timeout}, 32'd0);
    chk("wr_data_hold", per_data_in, 32'hDEADBEEF);
    consume();

    // 8-bit read, ready immediately
    per_data_out = 32'h12345678;
    per_data_ready = 1'b1;
    req(1'b0, 2'b00, 6'h04, 32'h0);
    chk("rd8_strobe", {30'b0, per_data_read_n}, 32'd0);
    chk("rd8_addr", {26'b0, per_address}, 32'd4);
    tick();
    chk("rd8_release", {30'b0, per_data_read_n}, 32'd3);
    chk("rd8_rsp", {31'b0, rsp_valid}, 32'd1);
    chk("rd8_rdata", rsp_rdata, 32'h00000078);
    chk("rd8_addr_hold", {26'b0, per_address}, 32'd4);
    per_data_ready = 1'b0;
    consume();

    // 16-bit read, ready in the 4th bus cycle
    per_data_out = 32'hCAFEF00D;
    req(1'b0, 2'b01, 6'h08, 32'h0);
    chk("rd16_c1", {30'b0, per_data_read_n}, 32'd1);
    tick();
    chk("rd16_c2", {30'b0, per_data_read_n}, 32'd1);
    tick();
    chk("rd16_c3", {30'b0, per_data_read_n}, 32'd1);
    tick();
    chk("rd16_c4", {30'b0, per_data_read_n}, 32'd1);
    chk("rd16_no_rsp", {31'b0, rsp_valid}, 32'd0);
    per_data_ready = 1'b1;
    tick();
    per_data_ready = 1'b0;
    chk("rd16_release", {30'b0, per_data_read_n}, 32'd3);
    chk("rd16_rsp", {31'b0, rsp_valid}, 32'd1);
    chk("rd16_rdata", rsp_rdata, 32'h0000F00D);
    consume();

    // 32-bit read that times out
    req(1'b0, 2'b10, 6'h10, 32'h0);
    for (int i = 0; i < 16; i++) begin
      chk("to_strobe", {30'b0, per_data_read_n}, 32'd2);
      chk("to_pending", {31'b0, rsp_valid}, 32'd0);
      tick();
    end
    chk("to_release", {30'b0, per_data_read_n}, 32'd3);
    chk("to_rsp", {31'b0, rsp_valid}, 32'd1);
    chk("to_flag", {31'b0, rsp_timeout}, 32'd1);
    chk("to_rdata", rsp_rdata, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("to_hold_valid", {31'b0, rsp_valid}, 32'd1);
      chk("to_hold_busy", {31'b0, req_ready}, 32'd0);
      chk("to_hold_flag", {31'b0, rsp_timeout}, 32'd1);
    end
    consume();
    chk("to_flag_clr", {31'b0, rsp_timeout}, 32'd0);

    // ready on the final allowed cycle beats the timeout
    per_data_out = 32'hA5A55A5A;
    req(1'b0, 2'b10, 6'h14, 32'h0);
    for (int i = 0; i < 15; i++) tick();
    chk("last_strobe", {30'b0, per_data_read_n}, 32'd2);
    per_data_ready = 1'b1;
    tick();
    per_data_ready = 1'b0;
    chk("last_rsp", {31'b0, rsp_valid}, 32'd1);
    chk("last_no_to", {31'b0, rsp_timeout}, 32'd0);
    chk("last_rdata", rsp_rdata, 32'hA5A55A5A);
    consume();

    // illegal size
    req(1'b1, 2'b11, 6'h20, 32'h11111111);
    chk("ill_err", {31'b0, rsp_err}, 32'd1);
    chk("ill_rsp", {31'b0, rsp_valid}, 32'd1);
    chk("ill_wr_n", {30'b0, per_data_write_n}, 32'd3);
    chk("ill_rd_n", {30'b0, per_data_read_n}, 32'd3);
    chk("ill_rdata", rsp_rdata, 32'd0);
    tick();
    chk("ill_wr_n2", {30'b0, per_data_write_n}, 32'd3);
    consume();
    chk("ill_err_clr", {31'b0, rsp_err}, 32'd0);

    // interrupt edges: 1,1,0,1,0,0
    per_user_interrupt = 1'b1;
    tick();
    chk("irq_rise1", {31'b0, irq_rise}, 32'd1);
    pulses += int'(irq_rise);
    tick();
    chk("irq_level", {31'b0, irq_rise}, 32'd0);
    pulses += int'(irq_rise);
    per_user_interrupt = 1'b0;
    tick();
    chk("irq_fall", {31'b0, irq_rise}, 32'd0);
    pulses += int'(irq_rise);
    per_user_interrupt = 1'b1;
    tick();
    chk("irq_rise2", {31'b0, irq_rise}, 32'd1);
    pulses += int'(irq_rise);
    per_user_interrupt = 1'b0;
    tick();
    pulses += int'(irq_rise);
    tick();
    pulses += int'(irq_rise);
    chk("irq_count", pulses, 32'd2);

    // reset during a pending read
    req(1'b0, 2'b10, 6'h18, 32'h0);
    chk("mid_strobe", {30'b0, per_data_read_n}, 32'd2);
    rst_n = 1'b0;
    tick();
    chk("mid_rd_n", {30'b0, per_data_read_n}, 32'd3);
    chk("mid_rsp", {31'b0, rsp_valid}, 32'd0);
    chk("mid_ready", {31'b0, req_ready}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("mid_ready_back", {31'b0, req_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
